spi_slave_rx: RTL and testbench

SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

---
 rtl/spi_slave_rx.sv | 160 ++++++++++++++++
 tb/tb_spi_slave_rx.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: oversampled SPI receiver with synchronisers and word storage.
// Define SPI_RX_FIFO_EN for a 4-entry FIFO instead of a single holding register.
module spi_slave_rx #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spi_cs_l,
  input  logic             spi_clk,
  input  logic             spi_data,
  input  logic             rx_ready,
  input  logic             err_clr,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic [2:0]       rx_level,
  output logic [4:0]       bit_count,
  output logic             frame_err,
  output logic             overrun
);

  localparam logic [4:0] LAST = 5'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_END} state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] cs_q, ck_q, dt_q, live_q;
  logic                   clk_prev_q, armed_q;
  logic [WIDTH-2:0]       shreg_q;
  logic [4:0]             bcnt_q;
  logic                   ferr_q, ovr_q;

  logic             cs_s, ck_s, dt_s, live;
  logic             rise, done, ferr_ev, ovr_ev;
  logic             full, pop, accept;
  logic [WIDTH-1:0] word;

  assign cs_s    = cs_q[SYNC_STAGES-1];
  assign ck_s    = ck_q[SYNC_STAGES-1];
  assign dt_s    = dt_q[SYNC_STAGES-1];
  assign live    = live_q[SYNC_STAGES-1];
  assign rise    = ck_s & ~clk_prev_q;
  assign word    = {shreg_q, dt_s};
  assign done    = (state_q == SHIFT) & ~cs_s & rise
                 & (bcnt_q == LAST);
  assign ferr_ev = (state_q == SHIFT) & cs_s & (bcnt_q != 5'd0);
  assign accept  = done & (~full | pop);
  assign ovr_ev  = done & full & ~pop;

  // live_q marks when the synchronisers hold real samples, not reset values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_q       <= '1;
      ck_q       <= '0;
      dt_q       <= '0;
      live_q     <= '0;
      clk_prev_q <= 1'b0;
    end else begin
      cs_q       <= {cs_q[SYNC_STAGES-2:0], spi_cs_l};
      ck_q       <= {ck_q[SYNC_STAGES-2:0], spi_clk};
      dt_q       <= {dt_q[SYNC_STAGES-2:0], spi_data};
      live_q     <= {live_q[SYNC_STAGES-2:0], 1'b1};
      clk_prev_q <= ck_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      shreg_q <= '0;
      armed_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      armed_q <= armed_q | (live & cs_s);
      ferr_q  <= (ferr_q & ~err_clr) | ferr_ev;
      ovr_q   <= (ovr_q & ~err_clr) | ovr_ev;
      unique case (state_q)
        IDLE: begin
          if (~cs_s && armed_q) begin
            state_q <= SHIFT;
            bcnt_q  <= '0;
          end
        end
        SHIFT: begin
          if (cs_s) begin
            state_q <= IDLE;
            bcnt_q  <= '0;
          end else if (rise) begin
            shreg_q <= word[WIDTH-2:0];
            bcnt_q  <= bcnt_q + 5'd1;
            if (bcnt_q == LAST) state_q <= WAIT_END;
          end
        end
        WAIT_END: begin
          if (cs_s) begin
            state_q <= IDLE;
            bcnt_q  <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SPI_RX_FIFO_EN
  logic [WIDTH-1:0] mem_q [4];
  logic [1:0]       wp_q, rp_q;
  logic [2:0]       cnt_q;

  assign full = cnt_q[2];
  assign pop  = (cnt_q != 3'd0) & rx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (accept) begin
        mem_q[wp_q] <= word;
        wp_q        <= wp_q + 2'd1;
      end
      if (pop) rp_q <= rp_q + 2'd1;
      cnt_q <= cnt_q + {2'b00, accept} - {2'b00, pop};
    end
  end

  assign rx_data  = mem_q[rp_q];
  assign rx_valid = (cnt_q != 3'd0);
  assign rx_level = cnt_q;
`else
  logic [WIDTH-1:0] hold_q;
  logic             hvld_q;

  assign full = hvld_q;
  assign pop  = hvld_q & rx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
      hvld_q <= 1'b0;
    end else begin
      if (accept) hold_q <= word;
      hvld_q <= accept | (hvld_q & ~pop);
    end
  end

  assign rx_data  = hold_q;
  assign rx_valid = hvld_q;
  assign rx_level = {2'b00, hvld_q};
`endif

  assign bit_count = bcnt_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: directed SPI frames checked against a word-level model.
// Build with SPI_RX_FIFO_EN defined to exercise the FIFO variant.
module tb_spi_slave_rx;

  localparam int W = 16;
  localparam int S = 2;
`ifdef SPI_RX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic         clk = 1'b0;
  logic         rst, spi_cs_l, spi_clk, spi_data;
  logic         rx_ready, err_clr;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic [2:0]   rx_level;
  logic [4:0]   bit_count;
  logic         frame_err, overrun;

  int tests = 0;
  int fails = 0;
  int cons_cnt = 0;
  logic [W-1:0] cons_last = '0;

  always #5 clk = ~clk;

  spi_slave_rx #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst),
    .spi_cs_l(spi_cs_l), .spi_clk(spi_clk), .spi_data(spi_data),
    .rx_ready(rx_ready), .err_clr(err_clr),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_level(rx_level),
    .bit_count(bit_count), .frame_err(frame_err), .overrun(overrun)
  );

  // Model: the design sees each pin S clk edges late; h*[k] is the
  // sample taken k+1 edges ago, hr marks samples taken out of reset.
  logic         hc [0:S];
  logic         hk [0:S];
  logic         hd [0:S];
  logic         hr [0:S];
  int           mode;
  int           bits;
  logic         armed;
  logic [W-1:0] acc;
  logic [W-1:0] q [$];
  logic         m_ferr, m_ovr;

  always @(posedge clk) begin : model
    logic cs, ck, ckp, d, rl, pop, push, fe, oe;
    if (rst) begin
      for (int i = 0; i <= S; i++) begin
        hc[i] = 1'b1; hk[i] = 1'b0; hd[i] = 1'b0; hr[i] = 1'b0;
      end
      mode = 0; bits = 0; armed = 1'b0; acc = '0;
      q.delete(); m_ferr = 1'b0; m_ovr = 1'b0;
    end else begin
      cs  = hc[S-1];
      ck  = hk[S-1];
      ckp = hk[S];
      d   = hd[S-1];
      rl  = hr[S-1];
      fe = 1'b0; oe = 1'b0; push = 1'b0;
      pop = (q.size() > 0) && rx_ready;
      if (mode == 0) begin
        if (!cs && armed) begin mode = 1; bits = 0; end
      end else if (mode == 1) begin
        if (cs) begin
          if (bits > 0) fe = 1'b1;
          mode = 0; bits = 0;
        end else if (ck && !ckp) begin
          acc = {acc[W-2:0], d};
          bits++;
          if (bits == W) begin push = 1'b1; mode = 2; end
        end
      end else begin
        if (cs) begin mode = 0; bits = 0; end
      end
      if (pop) void'(q.pop_front());
      if (push) begin
        if (q.size() < CAP) q.push_back(acc);
        else oe = 1'b1;
      end
      m_ferr = (m_ferr & ~err_clr) | fe;
      m_ovr  = (m_ovr & ~err_clr) | oe;
      if (cs && rl) armed = 1'b1;
      for (int i = S; i > 0; i--) begin
        hc[i] = hc[i-1]; hk[i] = hk[i-1]; hd[i] = hd[i-1]; hr[i] = hr[i-1];
      end
      hc[0] = spi_cs_l; hk[0] = spi_clk; hd[0] = spi_data; hr[0] = 1'b1;
    end
  end

  always @(negedge clk) begin : compare
    logic ev;
    if (!rst) begin
      ev = (q.size() > 0);
      tests++;
      if (rx_valid !== ev || rx_level !== 3'(q.size())
          || bit_count !== 5'(bits) || frame_err !== m_ferr
          || overrun !== m_ovr || (ev && rx_data !== q[0])) begin
        fails++;
        $display("FAIL cycle @%0t: got v=%b d=%h lvl=%0d bc=%0d fe=%b ov=%b, need v=%b d=%h lvl=%0d bc=%0d fe=%b ov=%b",
                 $time, rx_valid, rx_data, rx_level, bit_count, frame_err,
                 overrun, ev, ev ? q[0] : '0, q.size(), bits, m_ferr, m_ovr);
      end
      if (rx_valid && rx_ready) begin
        cons_cnt++;
        cons_last = rx_data;
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h need %0h", name, got, exp);
    end
  endtask

  task automatic spi_bit(logic b);
    spi_data = b;
    tick(4);
    spi_clk = 1'b1;
    tick(4);
    spi_clk = 1'b0;
  endtask

  task automatic send(logic [W-1:0] w, int n);
    for (int i = 0; i < n; i++) spi_bit(w[W-1-i]);
  endtask

  task automatic cs_low();
    spi_cs_l = 1'b0;
    tick(4);
  endtask

  task automatic cs_high();
    tick(4);
    spi_cs_l = 1'b1;
    tick(8);
  endtask

  task automatic frame(logic [W-1:0] w);
    cs_low();
    send(w, W);
    cs_high();
  endtask

  task automatic clr_err();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(1);
  endtask

  initial begin
    rst = 1'b1; spi_cs_l = 1'b1; spi_clk = 1'b0; spi_data = 1'b0;
    rx_ready = 1'b0; err_clr = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(S + 4);

    chk("rst_data", rx_data, 0);
    chk("rst_valid", rx_valid, 0);
    chk("rst_level", rx_level, 0);
    chk("rst_bits", bit_count, 0);
    chk("rst_flags", {frame_err, overrun}, 0);

    rx_ready = 1'b1;
    cons_cnt = 0;
    cs_low();
    send(16'hA5C3, W);
    tick(4);
    chk("a5c3_bits16", bit_count, 16);
    cs_high();
    chk("a5c3_words", cons_cnt, 1);
    chk("a5c3_data", cons_last, 16'hA5C3);
    chk("a5c3_bits0", bit_count, 0);
    chk("a5c3_flags", {frame_err, overrun}, 0);

    cons_cnt = 0;
    cs_low();
    send(16'hFFFF, 7);
    cs_high();
    chk("abort_words", cons_cnt, 0);
    chk("abort_ferr", frame_err, 1);
    frame(16'h1234);
    chk("after_abort_words", cons_cnt, 1);
    chk("after_abort_data", cons_last, 16'h1234);
    chk("ferr_sticky", frame_err, 1);
    clr_err();
    chk("ferr_clr", frame_err, 0);

    rx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      frame(W'(i));
`ifdef SPI_RX_FIFO_EN
      if (i == 4) begin
        chk("fifo4_ovr", overrun, 0);
        chk("fifo4_level", rx_level, 4);
      end
`else
      if (i == 2) begin
        chk("hold2_ovr", overrun, 1);
        chk("hold2_data", rx_data, 1);
      end
`endif
    end
    chk("full_ovr", overrun, 1);
    chk("full_level", rx_level, CAP);
    for (int k = 1; k <= CAP; k++) begin
      chk("drain_data", rx_data, k);
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
      tick(1);
    end
    chk("drained_valid", rx_valid, 0);
    clr_err();
    chk("ovr_clr", overrun, 0);

    for (int k = 1; k <= CAP; k++) frame(W'(16'h0100 + k));
    cs_low();
    send(16'hBEEF, W - 1);
    spi_data = 1'b1;
    tick(4);
    spi_clk = 1'b1;
    tick(S);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    tick(1);
    spi_clk = 1'b0;
    cs_high();
    chk("coinc_ovr", overrun, 0);
    chk("coinc_level", rx_level, CAP);
`ifdef SPI_RX_FIFO_EN
    chk("coinc_head", rx_data, 16'h0102);
`else
    chk("coinc_head", rx_data, 16'hBEEF);
`endif
    rx_ready = 1'b1;
    tick(CAP + 2);
    chk("coinc_last", cons_last, 16'hBEEF);
    chk("coinc_empty", rx_level, 0);

    cons_cnt = 0;
    cs_low();
    repeat (20) spi_bit(1'b1);
    tick(4);
    chk("long_bits", bit_count, 16);
    cs_high();
    chk("long_words", cons_cnt, 1);
    chk("long_data", cons_last, 16'hFFFF);
    chk("long_flags", {frame_err, overrun}, 0);

    cons_cnt = 0;
    cs_low();
    send(16'h5555, 9);
    rst = 1'b1;
    tick(2);
    chk("mrst_data", rx_data, 0);
    chk("mrst_valid", rx_valid, 0);
    chk("mrst_level", rx_level, 0);
    chk("mrst_bits", bit_count, 0);
    chk("mrst_flags", {frame_err, overrun}, 0);
    rst = 1'b0;
    repeat (7) spi_bit(1'b1);
    tick(4);
    chk("mrst_idle_bits", bit_count, 0);
    chk("mrst_idle_words", cons_cnt, 0);
    cs_high();
    chk("mrst_ferr", frame_err, 0);
    frame(16'h8001);
    chk("mrst_words", cons_cnt, 1);
    chk("mrst_next", cons_last, 16'h8001);
    chk("mrst_flags2", {frame_err, overrun}, 0);

    tick(4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
